// File: rtl/temporizer_cmd_scheduler_pkg.sv
// Shared types for the countdown-timer command front-end: command codes and event source indices.
package temporizer_cmd_scheduler_pkg;

   localparam int CMD_W   = 3;
   localparam int NUM_SRC = 6;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP   = 3'd0,
      CMD_TICK  = 3'd1,
      CMD_ONOFF = 3'd2,
      CMD_UP    = 3'd3,
      CMD_DOWN  = 3'd4,
      CMD_LEFT  = 3'd5,
      CMD_RIGHT = 3'd6
   } cmd_e;

   // Source index order doubles as button priority: a lower index wins (ONOFF > UP > DOWN > LEFT > RIGHT).
   localparam int SRC_TICK  = 0;
   localparam int SRC_ONOFF = 1;
   localparam int SRC_UP    = 2;
   localparam int SRC_DOWN  = 3;
   localparam int SRC_LEFT  = 4;
   localparam int SRC_RIGHT = 5;

   function automatic cmd_e src2cmd(input logic [CMD_W-1:0] src);
      return cmd_e'(src + 3'd1);
   endfunction

endpackage

// File: rtl/temporizer_cmd_scheduler_if.sv
// Command handshake between the scheduler (master) and the timer core (slave).
interface temporizer_cmd_scheduler_if;
   logic                              cmd_valid;
   temporizer_cmd_scheduler_pkg::cmd_e cmd_code;
   logic                              cmd_ready;

   modport master (output cmd_valid, output cmd_code, input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_code, output cmd_ready);
endinterface

// File: rtl/temporizer_cmd_scheduler_sync_edge_detect.sv
// Synchroniser chain plus previous-value flop; emits a one-cycle pulse on each synchronised rising edge.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
endmodule

// File: rtl/temporizer_cmd_scheduler.sv
// Turns async button/tick edges into a single clk-domain command stream (pending bits, FIFO, output reg).
// Optional UP/DOWN auto-repeat is enabled by defining TEMP_CMD_AUTOREPEAT_EN.
module temporizer_cmd_scheduler
   import temporizer_cmd_scheduler_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FIFO_DEPTH    = 4,
   parameter int REPEAT_DELAY  = 50,
   parameter int REPEAT_PERIOD = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              sec,
   input  logic                              btn_up,
   input  logic                              btn_down,
   input  logic                              btn_left,
   input  logic                              btn_right,
   input  logic                              btn_onoff,
   temporizer_cmd_scheduler_if.master        cmd,
   output logic                              overflow,
   output logic [7:0]                        drop_count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [NUM_SRC-1:0] raw, lvl, rise, evt, pend, pend_clr, drop;

   assign raw = {btn_right, btn_left, btn_down, btn_up, btn_onoff, sec};

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rst_n(rst_n),
         .din  (raw[i]),
         .level(lvl[i]),
         .rise (rise[i])
      );
   end

`ifdef TEMP_CMD_AUTOREPEAT_EN
   localparam int RC_W = $clog2(REPEAT_DELAY + 1);
   logic [RC_W-1:0] rpt_cnt;
   logic            hold_one, rpt_fire;
   logic [NUM_SRC-1:0] rpt_mask;

   // Count restarts whenever neither or both of UP/DOWN are held; first fire lands REPEAT_DELAY cycles after the edge.
   assign hold_one = lvl[SRC_UP] ^ lvl[SRC_DOWN];
   assign rpt_fire = hold_one && (rpt_cnt == RC_W'(REPEAT_DELAY - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rpt_cnt <= '0;
      else if (!hold_one) rpt_cnt <= '0;
      else if (rpt_fire) rpt_cnt <= RC_W'(REPEAT_DELAY - REPEAT_PERIOD);
      else               rpt_cnt <= rpt_cnt + RC_W'(1);
   end

   always_comb begin
      rpt_mask           = '0;
      rpt_mask[SRC_UP]   = 1'b1;
      rpt_mask[SRC_DOWN] = 1'b1;
   end

   assign evt = rise | ({NUM_SRC{rpt_fire}} & lvl & rpt_mask);
`else
   logic unused_lvl;
   assign unused_lvl = ^lvl;
   assign evt        = rise;
`endif

   // FIFO: the presented command stays in its slot until accepted, so the output reg adds no extra capacity.
   cmd_e             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0]   fifo_cnt;
   logic             full, accept, pop, push, load, load_tick, load_fifo, head_avail, out_fifo;
   logic [CMD_W-1:0] push_src;
   cmd_e             head;

   assign full       = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
   assign accept     = cmd.cmd_valid & cmd.cmd_ready;
   assign pop        = accept & out_fifo;
   assign load       = ~cmd.cmd_valid | accept;
   assign head       = fifo_mem[rd_ptr + PTR_W'(pop)];
   assign head_avail = (fifo_cnt > (PTR_W+1)'(pop));
   assign load_tick  = load & pend[SRC_TICK];
   assign load_fifo  = load & ~pend[SRC_TICK] & head_avail;

   always_comb begin
      push_src = '0;
      for (int i = NUM_SRC - 1; i >= 1; i--)
         if (pend[i]) push_src = CMD_W'(i);
      push = (|pend[NUM_SRC-1:1]) & (~full | pop);

      pend_clr = '0;
      if (load_tick) pend_clr[SRC_TICK] = 1'b1;
      if (push)      pend_clr[push_src] = 1'b1;
   end

   assign drop = evt & pend & ~pend_clr;

   logic [8:0] drop_sum;
   assign drop_sum = {1'b0, drop_count} + 9'($countones(drop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         pend       <= (pend & ~pend_clr) | evt;
         overflow   <= overflow | (|drop);
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= src2cmd(push_src);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd.cmd_valid <= 1'b0;
         cmd.cmd_code  <= CMD_NOP;
         out_fifo      <= 1'b0;
      end else if (load) begin
         if (load_tick) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_code  <= CMD_TICK;
            out_fifo      <= 1'b0;
         end else if (load_fifo) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_code  <= head;
            out_fifo      <= 1'b1;
         end else begin
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_code  <= CMD_NOP;
            out_fifo      <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_temporizer_cmd_scheduler.sv
// Directed bench for temporizer_cmd_scheduler with default parameters (SYNC_STAGES=2, FIFO_DEPTH=4).
module tb_temporizer_cmd_scheduler;
   logic clk = 1'b0;
   logic rst_n;
   logic sec, btn_up, btn_down, btn_left, btn_right, btn_onoff;
   logic overflow;
   logic [7:0] drop_count;
   int total = 0;
   int bad   = 0;

   temporizer_cmd_scheduler_if cif ();

   temporizer_cmd_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sec       (sec),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_onoff (btn_onoff),
      .cmd       (cif),
      .overflow  (overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Step n rising edges, then settle 1 time unit so registered outputs are stable.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int exp_up;
      rst_n = 1'b0; sec = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_onoff = 0;
      cif.cmd_ready = 1'b0;
      #3;
      chk("rst_valid", int'(cif.cmd_valid), 0);
      chk("rst_code", int'(cif.cmd_code), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_drop", int'(drop_count), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // single UP pulse: valid for exactly one cycle at SYNC_STAGES+3
      cif.cmd_ready = 1'b1;
      btn_up = 1'b1;
      cyc(4);
      chk("up_early", int'(cif.cmd_valid), 0);
      cyc(1);
      chk("up_valid", int'(cif.cmd_valid), 1);
      chk("up_code", int'(cif.cmd_code), 3);
      cyc(1);
      chk("up_gone", int'(cif.cmd_valid), 0);
      btn_up = 1'b0;
      cyc(6);

      // simultaneous ONOFF, LEFT, TICK -> TICK, ONOFF, LEFT
      btn_onoff = 1'b1; btn_left = 1'b1; sec = 1'b1;
      cyc(3);
      chk("mix_early", int'(cif.cmd_valid), 0);
      cyc(1);
      chk("mix_c0", int'(cif.cmd_code), 1);
      cyc(1);
      chk("mix_c1", int'(cif.cmd_code), 2);
      cyc(1);
      chk("mix_c2", int'(cif.cmd_code), 5);
      cyc(1);
      chk("mix_end", int'(cif.cmd_valid), 0);
      btn_onoff = 1'b0; btn_left = 1'b0; sec = 1'b0;
      cyc(6);

      // backpressure: 8 DOWN edges, 4 in FIFO, 1 pending, 3 dropped
      cif.cmd_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         btn_down = 1'b1; cyc(5);
         btn_down = 1'b0; cyc(5);
      end
      chk("bp_drop", int'(drop_count), 3);
      chk("bp_ovf", int'(overflow), 1);
      chk("bp_fifo", int'(dut.fifo_cnt), 4);
      chk("bp_pend", int'(dut.pend[3]), 1);
      chk("bp_code", int'(cif.cmd_code), 4);
      cif.cmd_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (cif.cmd_valid && cif.cmd_code == 3'd4) n++;
         cyc(1);
      end
      chk("bp_xfers", n, 5);

      // presented RIGHT must not be preempted by a later TICK
      cif.cmd_ready = 1'b0;
      btn_right = 1'b1;
      cyc(6);
      btn_right = 1'b0;
      chk("hold_code0", int'(cif.cmd_code), 6);
      sec = 1'b1;
      cyc(8);
      sec = 1'b0;
      chk("hold_code1", int'(cif.cmd_code), 6);
      cif.cmd_ready = 1'b1;
      cyc(1);
      chk("hold_next", int'(cif.cmd_code), 1);
      chk("hold_nextv", int'(cif.cmd_valid), 1);
      cyc(4);

      // UP held 100 cycles: auto-repeat only when enabled
`ifdef TEMP_CMD_AUTOREPEAT_EN
      exp_up = 7;
`else
      exp_up = 1;
`endif
      n = 0;
      btn_up = 1'b1;
      for (int k = 0; k < 130; k++) begin
         if (k == 100) btn_up = 1'b0;
         if (cif.cmd_valid && cif.cmd_code == 3'd3) n++;
         cyc(1);
      end
      chk("rpt_count", n, exp_up);

      // async reset mid-stream while a command is presented
      cif.cmd_ready = 1'b0;
      btn_left = 1'b1;
      cyc(6);
      btn_left = 1'b0;
      chk("ar_pre", int'(cif.cmd_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", int'(cif.cmd_valid), 0);
      chk("ar_code", int'(cif.cmd_code), 0);
      chk("ar_drop", int'(drop_count), 0);
      chk("ar_ovf", int'(overflow), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
